regfile_scan_checker: RTL and testbench

//  Synthesizable, parametrised successor to the simulation-only run/scan/compare harness.

---
 rtl/regfile_scan_pkg.sv | 12 +
 rtl/scan_trace_fifo.sv | 46 ++++
 rtl/regfile_scan_checker.sv | 117 +++++++++++
 tb/tb_regfile_scan_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scan_pkg.sv
// regfile_scan_pkg: shared FSM state encoding and trace entry layout for regfile_scan_checker.
package regfile_scan_pkg;
  typedef enum logic [2:0] {IDLE, RUN, SCAN_REQ, SCAN_CMP, DONE} state_t;
  typedef struct packed {
    logic [15:0] cycle;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_entry_t;
  function automatic int trace_w(input int cyc_w, input int aw, input int dw);
    return cyc_w + aw + dw;
  endfunction
endpackage

// File: rtl/scan_trace_fifo.sv
// scan_trace_fifo: synchronous writeback trace FIFO with sticky overflow and flush.
module scan_trace_fifo #(
  parameter int W     = 53,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full,
  output logic         o_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic         r_ovf;
  logic         w_empty, w_pop, w_push;
  assign w_empty    = r_wr == r_rd;
  assign o_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop      = i_pop && !w_empty;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_valid    = !w_empty;
  assign o_overflow = r_ovf;
  assign o_data     = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wr  <= r_wr + (AW+1)'(w_push);
      r_rd  <= r_rd + (AW+1)'(w_pop);
      r_ovf <= r_ovf | (i_push && !w_push);
    end
  always_ff @(posedge clock)
    if (w_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/regfile_scan_checker.sv
// regfile_scan_checker: runs the core for num_cycles tracing writebacks, then scans and checks the regfile.
// Define SCAN_DUMP_EN to add the dump_valid/dump_reg/dump_data scan log outputs.
module regfile_scan_checker
  import regfile_scan_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = 5,
  parameter int DATA_W      = 32,
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic                                       start,
  input  logic [CYC_W-1:0]                           num_cycles,
  input  logic                                       wb_we,
  input  logic [REG_AW-1:0]                          wb_rd,
  input  logic [DATA_W-1:0]                          wb_data,
  output logic                                       test_mode,
  output logic [REG_AW-1:0]                          scan_addr,
  input  logic [DATA_W-1:0]                          scan_data,
  output logic [REG_AW-1:0]                          exp_addr,
  input  logic [DATA_W-1:0]                          exp_data,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       pass,
  output logic [REG_AW:0]                            err_count,
  output logic                                       first_err_valid,
  output logic [REG_AW-1:0]                          first_err_reg,
  output logic [CYC_W-1:0]                           cycle_count,
  output logic                                       trace_valid,
  input  logic                                       trace_pop,
  output logic [trace_w(CYC_W, REG_AW, DATA_W)-1:0]  trace_data,
  output logic                                       trace_overflow
`ifdef SCAN_DUMP_EN
  ,
  output logic                                       dump_valid,
  output logic [REG_AW-1:0]                          dump_reg,
  output logic [DATA_W-1:0]                          dump_data
`endif
);
  localparam logic [REG_AW-1:0] LAST = REG_AW'(NUM_REGS - 1);
  state_t              r_state;
  logic [CYC_W-1:0]    r_num, r_cyc;
  logic [REG_AW-1:0]   r_idx, r_first;
  logic [REG_AW:0]     r_err;
  logic                r_first_v;
  logic                w_accept, w_push, w_mis, w_full;
  assign w_accept        = start && (r_state == IDLE || r_state == DONE);
  // the terminal RUN cycle (count reached) is a hand-off cycle and traces nothing
  assign w_push          = r_state == RUN && r_cyc != r_num && wb_we && wb_rd != '0;
  assign w_mis           = r_state == SCAN_CMP && scan_data !== exp_data;
  assign test_mode       = r_state == SCAN_REQ || r_state == SCAN_CMP;
  assign busy            = r_state == RUN || test_mode;
  assign done            = r_state == DONE;
  assign pass            = done && r_err == '0;
  assign err_count       = r_err;
  assign first_err_valid = r_first_v;
  assign first_err_reg   = r_first;
  assign cycle_count     = r_cyc;
  assign scan_addr       = r_idx;
  assign exp_addr        = r_idx;
`ifdef SCAN_DUMP_EN
  assign dump_valid      = r_state == SCAN_CMP;
  assign dump_reg        = r_idx;
  assign dump_data       = scan_data;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_num     <= '0;
      r_cyc     <= '0;
      r_idx     <= '0;
      r_err     <= '0;
      r_first_v <= 1'b0;
      r_first   <= '0;
    end else if (w_accept) begin
      r_state   <= RUN;
      r_num     <= num_cycles;
      r_cyc     <= '0;
      r_idx     <= '0;
      r_err     <= '0;
      r_first_v <= 1'b0;
      r_first   <= '0;
    end else
      case (r_state)
        RUN:      if (r_cyc == r_num) r_state <= SCAN_REQ; else r_cyc <= r_cyc + 1'b1;
        SCAN_REQ: r_state <= SCAN_CMP;
        SCAN_CMP: begin
          if (w_mis) begin
            r_err <= &r_err ? r_err : r_err + 1'b1;
            if (!r_first_v) begin
              r_first_v <= 1'b1;
              r_first   <= r_idx;
            end
          end
          r_state <= r_idx == LAST ? DONE : SCAN_REQ;
          r_idx   <= r_idx == LAST ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
  scan_trace_fifo #(
    .W     (trace_w(CYC_W, REG_AW, DATA_W)),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_flush    (w_accept),
    .i_push     (w_push),
    .i_data     ({r_cyc, wb_rd, wb_data}),
    .i_pop      (trace_pop),
    .o_data     (trace_data),
    .o_valid    (trace_valid),
    .o_full     (w_full),
    .o_overflow (trace_overflow)
  );
endmodule

// File: tb/tb_regfile_scan_checker.sv
// tb_regfile_scan_checker: scoreboarded trace checks, table-driven scan vectors, reset/restart corner cases.
module tb_regfile_scan_checker;
  import regfile_scan_pkg::*;
  logic        clock = 0, reset_n = 0, start = 0, wb_we = 0, trace_pop = 0;
  logic [15:0] num_cycles = 0;
  logic [4:0]  wb_rd = 0;
  logic [31:0] wb_data = 0, scan_data, exp_q = 0;
  logic        test_mode, busy, done, pass, first_err_valid, trace_valid, trace_overflow;
  logic [4:0]  scan_addr, exp_addr, first_err_reg;
  logic [5:0]  err_count;
  logic [15:0] cycle_count;
  logic [52:0] trace_data;
  logic [31:0] rf [32];
  logic [31:0] ex [32];
  trace_entry_t sb [$];
  logic        exp_ovf;
  int          n_chk = 0, n_fail = 0;
`ifdef SCAN_DUMP_EN
  logic        dump_valid;
  logic [4:0]  dump_reg;
  logic [31:0] dump_data;
  int          dump_n = 0;
`endif

  regfile_scan_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_cycles(num_cycles),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .test_mode(test_mode),
    .scan_addr(scan_addr), .scan_data(scan_data), .exp_addr(exp_addr), .exp_data(exp_q),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_reg(first_err_reg),
    .cycle_count(cycle_count), .trace_valid(trace_valid), .trace_pop(trace_pop),
    .trace_data(trace_data), .trace_overflow(trace_overflow)
`ifdef SCAN_DUMP_EN
    , .dump_valid(dump_valid), .dump_reg(dump_reg), .dump_data(dump_data)
`endif
  );

  always #5 clock = ~clock;
  assign scan_data = rf[scan_addr];
  always @(posedge clock) exp_q <= ex[exp_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

`ifdef SCAN_DUMP_EN
  always @(negedge clock)
    if (dump_valid) begin
      chk("dump_reg", 64'(dump_reg), 64'(dump_n));
      chk("dump_data", 64'(dump_data), 64'(rf[dump_reg]));
      dump_n++;
    end
`endif

  task automatic begin_run(input logic [15:0] n);
    @(negedge clock);
    start = 1; num_cycles = n;
    sb.delete(); exp_ovf = 0;
`ifdef SCAN_DUMP_EN
    dump_n = 0;
`endif
    @(negedge clock);
    start = 0; num_cycles = 16'($urandom);
  endtask

  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d, input int k, input logic pop);
    wb_we = we; wb_rd = rd; wb_data = d;
    if (pop) begin
      chk("pop_valid", 64'(trace_valid), 1);
      if (sb.size() > 0) chk("pop_head", 64'(trace_data), 64'(sb.pop_front()));
      trace_pop = 1;
    end
    if (we && rd != 0) begin
      if (sb.size() < 16) sb.push_back('{cycle: k[15:0], rd: rd, data: d});
      else exp_ovf = 1;
    end
    @(negedge clock);
    wb_we = 0; trace_pop = 0;
  endtask

  task automatic wait_done();
    int lat = 0, g = 0;
    while (!done && g < 300) begin
      lat += int'(test_mode);
      @(negedge clock);
      g++;
    end
    chk("scan_cycles", 64'(lat), 64);
    chk("done", 64'(done), 1);
`ifdef SCAN_DUMP_EN
    chk("dump_count", 64'(dump_n), 32);
`endif
  endtask

  task automatic drain(input int n_exp);
    int n = 0;
    while (trace_valid && n < 40) begin
      if (sb.size() > 0) chk("trace_head", 64'(trace_data), 64'(sb.pop_front()));
      trace_pop = 1;
      @(negedge clock);
      trace_pop = 0;
      n++;
    end
    chk("trace_count", 64'(n), 64'(n_exp));
    chk("sb_empty", 64'(sb.size()), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, 64'({test_mode, busy, done, pass, first_err_valid, trace_valid, trace_overflow}), 0);
    chk({nm, "_cnt"}, 64'({err_count, first_err_reg, cycle_count, scan_addr, exp_addr}), 0);
    chk({nm, "_trace"}, 64'(trace_data), 0);
  endtask

  typedef struct {
    logic [31:0] mask;
    logic [5:0]  err;
    logic        fv;
    logic [4:0]  freg;
    logic        pass;
  } vec_t;
  vec_t vt [5];

  initial begin
    vt[0] = '{32'h0000_0000, 6'd0, 1'b0, 5'd0, 1'b1};
    vt[1] = '{32'h0002_0010, 6'd2, 1'b1, 5'd4, 1'b0};
    vt[2] = '{32'h0000_0001, 6'd1, 1'b1, 5'd0, 1'b0};
    vt[3] = '{32'h8000_0000, 6'd1, 1'b1, 5'd31, 1'b0};
    vt[4] = '{32'hFFFF_FFFF, 6'd32, 1'b1, 5'd0, 1'b0};
    for (int i = 0; i < 32; i++) begin ex[i] = $urandom; rf[i] = ex[i]; end
    @(negedge clock);
    chk_zero("reset");
    reset_n = 1;

    // traced run: one real write, one r0 write
    begin_run(5);
    step(0, 0, 0, 0, 0);
    step(1, 3, 7, 1, 0);
    step(1, 0, 9, 2, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 4, 0);
    chk("run_busy", 64'(busy), 1);
    chk("run_test_mode", 64'(test_mode), 0);
    chk("run_cycles", 64'(cycle_count), 5);
    @(negedge clock);
    chk("scan_entry", 64'(test_mode), 1);
    wait_done();
    chk("run_cycles_hold", 64'(cycle_count), 5);
    drain(1);

    // fill to full, then push+pop on the full FIFO
    begin_run(17);
    for (int k = 0; k < 17; k++) step(1, 5'((k % 31) + 1), $urandom, k, k == 16);
    chk("ovf_pushpop", 64'(trace_overflow), 64'(exp_ovf));
    wait_done();
    drain(16);

    // overflow: 20 writes, no pops
    begin_run(20);
    for (int k = 0; k < 20; k++) step(1, 5'((k % 31) + 1), $urandom, k, 0);
    wait_done();
    chk("ovf_set", 64'(trace_overflow), 64'(exp_ovf));
    drain(16);

    // scan vectors, num_cycles=0 with a write in the lone RUN cycle
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) begin
        ex[i] = $urandom;
        rf[i] = vt[v].mask[i] ? ex[i] ^ (32'h1 << $urandom_range(31, 0)) : ex[i];
      end
      begin_run(0);
      chk("ovf_clear", 64'(trace_overflow), 0);
      wb_we = 1; wb_rd = 9; wb_data = 1;
      @(negedge clock);
      wb_we = 0;
      chk("zero_run_scan", 64'(test_mode), 1);
      wait_done();
      chk("err_count", 64'(err_count), 64'(vt[v].err));
      chk("first_valid", 64'(first_err_valid), 64'(vt[v].fv));
      chk("first_reg", 64'(first_err_reg), 64'(vt[v].freg));
      chk("pass", 64'(pass), 64'(vt[v].pass));
      chk("zero_run_trace", 64'(trace_valid), 0);
    end

    // start mid-RUN must be ignored
    for (int i = 0; i < 32; i++) rf[i] = ex[i];
    begin_run(10);
    for (int k = 0; k < 10; k++) begin
      start = k == 4; num_cycles = 2;
      step(0, 0, 0, k, 0);
      start = 0;
    end
    chk("restart_ignored", 64'(cycle_count), 10);
    chk("restart_busy", 64'(test_mode), 0);
    @(negedge clock);
    wait_done();
    chk("restart_pass", 64'(pass), 1);

    // asynchronous reset while in SCAN_CMP
    begin_run(3);
    step(0, 0, 0, 0, 0);
    step(1, 5, 32'hABCD, 1, 0);
    step(0, 0, 0, 2, 0);
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset", 64'({test_mode, trace_valid, cycle_count}), 64'({1'b1, 1'b1, 16'd3}));
    #2 reset_n = 0;
    #1 chk_zero("abort");
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    chk("idle_after_abort", 64'({busy, done}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
